// File: rtl/serial_word_capture_pkg.sv
// serial_pkg: shared types and constants for the serial word capture block.
//   - cap_state_t : capture FSM encoding (ST_IDLE, ST_SHIFT)
//   - ob_state_t  : output holding register encoding (OB_EMPTY, OB_FULL)
//   - DEF_WIDTH / DEF_PATTERN : default word width and match pattern
//   - cnt_width() : width of a counter that must hold values 0..n-1
package serial_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } cap_state_t;

  typedef enum logic {
    OB_EMPTY = 1'b0,
    OB_FULL  = 1'b1
  } ob_state_t;

  localparam int         DEF_WIDTH   = 8;
  localparam logic [7:0] DEF_PATTERN = 8'hA5;

  // Never returns zero so that a counter always has at least one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/serial_word_capture_if.sv
// Word output channel of serial_word_capture.
//   WORD_DATA  : assembled word, stable while WORD_VALID=1
//   WORD_VALID : word available
//   WORD_READY : consumer accepts the word when WORD_VALID & WORD_READY
//   MATCH      : WORD_DATA equals the expected pattern, 0 while WORD_VALID=0
// master = producer (the capture block), slave = consumer.
interface serial_word_capture_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] WORD_DATA;
  logic             WORD_VALID;
  logic             WORD_READY;
  logic             MATCH;

  modport master (output WORD_DATA, output WORD_VALID, output MATCH, input WORD_READY);
  modport slave  (input WORD_DATA, input WORD_VALID, input MATCH, output WORD_READY);
endinterface

// File: rtl/serial_word_capture_out_buffer.sv
// word_out_buffer: one-deep valid/ready holding register with sticky overrun.
//   clk, rst     : clock, synchronous active-high reset
//   load_valid   : a completed word is offered this cycle
//   load_data    : the offered word
//   ready        : consumer accepts the held word
//   clr_ovr      : clears the overrun flag (a simultaneous set wins)
//   data/valid/match/overrun : registered outputs
module word_out_buffer
  import serial_pkg::*;
#(
  parameter int               WIDTH   = DEF_WIDTH,
  parameter logic [WIDTH-1:0] PATTERN = WIDTH'(DEF_PATTERN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  input  logic             ready,
  input  logic             clr_ovr,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic             match,
  output logic             overrun
);

  ob_state_t        ob_state_r, ob_state_s;
  logic [WIDTH-1:0] data_r, data_s;
  logic             match_r, match_s;
  logic             ovr_r, ovr_s;
  logic             ovr_set_s;

  // Next-state logic for the holding register and overrun flag.
  always_comb begin
    ob_state_s = ob_state_r;
    data_s     = data_r;
    match_s    = match_r;
    ovr_set_s  = 1'b0;
    case (ob_state_r)
      OB_EMPTY: begin
        if (load_valid) begin
          ob_state_s = OB_FULL;
          data_s     = load_data;
          match_s    = (load_data == PATTERN);
        end else begin
          ob_state_s = OB_EMPTY;
        end
      end
      OB_FULL: begin
        if (ready) begin
          // Transfer; a word completing on the same edge refills immediately.
          if (load_valid) begin
            data_s  = load_data;
            match_s = (load_data == PATTERN);
          end else begin
            ob_state_s = OB_EMPTY;
            match_s    = 1'b0;
          end
        end else if (load_valid) begin
          // Held word wins; the new one is lost.
          ovr_set_s = 1'b1;
        end else begin
          ob_state_s = OB_FULL;
        end
      end
      default: begin
        ob_state_s = OB_EMPTY;
        match_s    = 1'b0;
      end
    endcase

    if (ovr_set_s) begin
      ovr_s = 1'b1;
    end else if (clr_ovr) begin
      ovr_s = 1'b0;
    end else begin
      ovr_s = ovr_r;
    end
  end

  // Holding register state.
  always_ff @(posedge clk) begin
    if (rst) begin
      ob_state_r <= OB_EMPTY;
      data_r     <= '0;
      match_r    <= 1'b0;
      ovr_r      <= 1'b0;
    end else begin
      ob_state_r <= ob_state_s;
      data_r     <= data_s;
      match_r    <= match_s;
      ovr_r      <= ovr_s;
    end
  end

  assign data    = data_r;
  assign valid   = (ob_state_r == OB_FULL);
  assign match   = match_r;
  assign overrun = ovr_r;

endmodule

// File: rtl/serial_word_capture.sv
// serial_word_capture: samples DIN on EN-high cycles, assembles WIDTH-bit
// words MSB first and presents them through a one-deep valid/ready buffer.
//   CLK, RST : clock, synchronous active-high reset
//   DIN, EN  : serial bit and its qualifier
//   wbus     : word output channel (WORD_DATA/WORD_VALID/WORD_READY/MATCH)
//   OVERRUN  : sticky, a completed word was dropped; CLR_OVR clears it
//   ABORT    : one-cycle pulse, partial word discarded after GAP_MAX idle cycles
//   BIT_CNT  : bits accumulated in the current partial word
module serial_word_capture
  import serial_pkg::*;
#(
  parameter int               WIDTH   = DEF_WIDTH,
  parameter logic [WIDTH-1:0] PATTERN = WIDTH'(DEF_PATTERN),
  parameter int               GAP_MAX = 4,
  localparam int              CW      = cnt_width(WIDTH)
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   DIN,
  input  logic                   EN,
  input  logic                   CLR_OVR,
  serial_word_capture_if.master  wbus,
  output logic                   OVERRUN,
  output logic                   ABORT,
  output logic [CW-1:0]          BIT_CNT
);

  localparam int GW = cnt_width(GAP_MAX + 1);

  cap_state_t       state_r, state_s;
  // Only WIDTH-1 history bits are needed; the newest bit comes from DIN.
  logic [WIDTH-2:0] shreg_r, shreg_s;
  logic [CW-1:0]    bit_cnt_r, bit_cnt_s;
  logic [GW-1:0]    gap_r, gap_s;
  logic             abort_r, abort_s;
  logic [WIDTH-1:0] word_s;
  logic             word_done_s;

  assign word_s = {shreg_r, DIN};

  // Capture FSM next-state, shift, bit count and gap timeout.
  always_comb begin
    state_s     = state_r;
    shreg_s     = shreg_r;
    bit_cnt_s   = bit_cnt_r;
    gap_s       = gap_r;
    abort_s     = 1'b0;
    word_done_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        gap_s = '0;
        if (EN) begin
          shreg_s   = word_s[WIDTH-2:0];
          bit_cnt_s = CW'(1);
          state_s   = ST_SHIFT;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (EN) begin
          shreg_s = word_s[WIDTH-2:0];
          gap_s   = '0;
          if (bit_cnt_r == CW'(WIDTH - 1)) begin
            bit_cnt_s   = '0;
            word_done_s = 1'b1;
            state_s     = ST_IDLE;
          end else begin
            bit_cnt_s = bit_cnt_r + CW'(1);
          end
        end else if (gap_r == GW'(GAP_MAX - 1)) begin
          // This idle cycle is the GAP_MAX-th in a row: drop the partial word.
          shreg_s   = '0;
          bit_cnt_s = '0;
          gap_s     = '0;
          abort_s   = 1'b1;
          state_s   = ST_IDLE;
        end else begin
          gap_s = gap_r + GW'(1);
        end
      end
      default: begin
        state_s   = ST_IDLE;
        shreg_s   = '0;
        bit_cnt_s = '0;
        gap_s     = '0;
      end
    endcase
  end

  // Capture state registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r   <= ST_IDLE;
      shreg_r   <= '0;
      bit_cnt_r <= '0;
      gap_r     <= '0;
      abort_r   <= 1'b0;
    end else begin
      state_r   <= state_s;
      shreg_r   <= shreg_s;
      bit_cnt_r <= bit_cnt_s;
      gap_r     <= gap_s;
      abort_r   <= abort_s;
    end
  end

  word_out_buffer #(
    .WIDTH   (WIDTH),
    .PATTERN (PATTERN)
  ) u_out (
    .clk        (CLK),
    .rst        (RST),
    .load_valid (word_done_s),
    .load_data  (word_s),
    .ready      (wbus.WORD_READY),
    .clr_ovr    (CLR_OVR),
    .data       (wbus.WORD_DATA),
    .valid      (wbus.WORD_VALID),
    .match      (wbus.MATCH),
    .overrun    (OVERRUN)
  );

  assign ABORT   = abort_r;
  assign BIT_CNT = bit_cnt_r;

endmodule

// File: doc/serial_word_capture.md
Name: serial_word_capture

Overview:
- Downstream consumer of the shift-register signal generator: samples the generated serial bit (generated_signal) on cycles where the data-enable (ENdin) is high.
- Assembles WIDTH-bit words, MSB first, and compares each word against an expected pattern.
- Presents words on a valid/ready output with a one-deep holding register, overrun detection and gap-timeout abort of partial words.
- Sits between the generator top and the checker/logging logic.

Parameters:
- WIDTH, 8, bits per assembled word (2..32).
- PATTERN, 8'hA5, expected word value for MATCH compare (WIDTH bits).
- GAP_MAX, 4, consecutive EN-low cycles that abort a partial word (>=1).

Ports:
- CLK  in  1  system clock, all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- DIN  in  1  serial data (generated_signal from the generator).
- EN  in  1  bit-valid qualifier (ENdin from the generator).
- WORD_DATA  out  WIDTH  assembled word; stable while WORD_VALID=1.
- WORD_VALID  out  1  output word available.
- WORD_READY  in  1  consumer accepts word when WORD_VALID&WORD_READY.
- MATCH  out  1  WORD_DATA==PATTERN; qualified by WORD_VALID.
- OVERRUN  out  1  sticky: a completed word was dropped.
- ABORT  out  1  one-cycle pulse: partial word discarded on gap timeout.
- CLR_OVR  in  1  clears OVERRUN (synchronous).
- BIT_CNT  out  $clog2(WIDTH)  bits accumulated in the current partial word.

Behaviour:
- Reset (RST=1 at edge): shift reg=0, BIT_CNT=0, gap counter=0, WORD_DATA=0, WORD_VALID=0, MATCH=0, OVERRUN=0, ABORT=0, FSM=IDLE. Reset mid-word discards the partial word and any held word.
- Capture: on each edge with EN=1, DIN shifts in at the LSB (shreg <= {shreg[WIDTH-2:0],DIN}) and BIT_CNT increments. With EN=0, shreg and BIT_CNT hold.
- Word complete: the edge where EN=1 and BIT_CNT==WIDTH-1. BIT_CNT wraps to 0 on that edge. The full word {shreg[WIDTH-2:0],DIN} is offered to the output register.
- Latency: WORD_VALID rises on the edge that samples the last bit, so it is visible the cycle after that bit is presented. Back-to-back words need no idle cycles.
- Capture FSM:
  - IDLE: BIT_CNT=0. EN=1 moves to SHIFT, or stays in IDLE when WIDTH==1-equivalent completion occurs.
  - SHIFT: 0<BIT_CNT<WIDTH. Word complete moves to IDLE. Gap timeout moves to IDLE.
- Gap timeout:
  - In SHIFT, a counter increments on each EN=0 cycle and resets to 0 on EN=1.
  - On reaching GAP_MAX, the partial word is discarded, BIT_CNT=0, ABORT=1 for one cycle, and the FSM returns to IDLE.
  - The gap counter does not run in IDLE.
- Output register (EMPTY/FULL):
  - EMPTY + word complete: load, VALID=1, MATCH updated.
  - FULL + READY=1: transfer; VALID falls unless a word completes on the same edge, in which case the new word loads and VALID stays 1.
  - FULL + READY=0 + word complete: new word dropped, held word unchanged, OVERRUN<=1.
- OVERRUN: sticky. CLR_OVR=1 clears it. A simultaneous set and CLR_OVR leaves OVERRUN=1 (set wins).
- MATCH: registered with WORD_DATA. Value is 0 when WORD_VALID=0.
- DIN/EN are synchronous to CLK; no input synchronisers are included.

Decomposition:
- Shared package serial_pkg: capture state encoding (ST_IDLE, ST_SHIFT), output state encoding (OB_EMPTY, OB_FULL), default WIDTH/PATTERN constants, and a counter-width function.
- One natural sub-module, word_out_buffer: a one-deep valid/ready register with overrun flag. The capture FSM stays in the top module.

Test Plan:
1. Reset then EN=1 for 8 cycles, DIN=1,0,1,0,0,1,0,1, READY=1 -> WORD_VALID=1 the cycle after the 8th bit for exactly one cycle, WORD_DATA=8'hA5, MATCH=1, BIT_CNT back to 0.
2. Two back-to-back words A5 then 3C, EN held high, READY=1 -> VALID high in cycles 9 and 17 only, data A5 then 3C, MATCH=1 then 0, OVERRUN=0.
3. Word 0x5A with EN low for 3 cycles after bit 4 (GAP_MAX=4) -> no abort; word completes as 0x5A; BIT_CNT holds at 4 during the gap.
4. 5 bits shifted, then EN low 4 cycles -> ABORT pulses once on the 4th low cycle, BIT_CNT=0, no VALID. The next 8 bits 0xFF produce WORD_DATA=8'hFF.
5. READY=0, words 0x11 then 0x22 -> WORD_DATA stays 0x11, OVERRUN=1 after the second word. READY=1 transfers 0x11. CLR_OVR pulse -> OVERRUN=0.
6. RST=1 asserted after bit 6 with a word held -> next cycle VALID=0, BIT_CNT=0, OVERRUN=0. A new full word 0xA5 after release is captured correctly.
